// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM pipeline stage and the data memory.
// master: the pipeline stage (drives request, write enable, address, write
//         data and byte enables; receives ack and read data).
// slave : the data memory (the reverse directions).
interface mem_stage_if;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        input  i_dmem_ack, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
        output i_dmem_ack, i_dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// RV32 memory-access pipeline stage.
// Consumes the EX->MEM register, issues loads/stores on the dmem bus with a
// req/ack handshake, steers store byte lanes, extracts and extends load data,
// stalls upstream while an access is outstanding and aborts hung accesses
// after ACK_TIMEOUT request cycles.
// Ports:
//   i_clk, i_reset (async, active-low)
//   EX->MEM inputs : i_valid, i_alu_out, i_store_data, i_write_reg, i_mem_read,
//                    i_mem_write, i_func3, i_mem_to_reg, i_reg_write,
//                    i_branch, i_branch_target
//   dmem           : data memory bus (mem_stage_if.master)
//   o_stall        : freeze upstream pipeline registers this cycle
//   MEM->WB        : o_wb_valid, o_wb_data, o_wb_reg, o_wb_reg_write
//   redirect       : o_pc_src, o_pc_target
//   o_mem_fault    : single-cycle pulse on misaligned/illegal access or timeout
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [31:0]        i_alu_out,
    input  logic [31:0]        i_store_data,
    input  logic [4:0]         i_write_reg,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    input  logic [2:0]         i_func3,
    input  logic               i_mem_to_reg,
    input  logic               i_reg_write,
    input  logic               i_branch,
    input  logic [31:0]        i_branch_target,
    mem_stage_if.master        dmem,
    output logic               o_stall,
    output logic               o_wb_valid,
    output logic [31:0]        o_wb_data,
    output logic [4:0]         o_wb_reg,
    output logic               o_wb_reg_write,
    output logic               o_pc_src,
    output logic [31:0]        o_pc_target,
    output logic               o_mem_fault
);

    typedef enum logic [0:0] {IDLE = 1'b0, REQ = 1'b1} state_t;

    // Abort fires on the edge closing the ACK_TIMEOUT-th request cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 32'd1);

    // Size/alignment legality of a load or store; read+write together is illegal.
    function automatic logic access_ok(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else if (wr) begin
            case (f3)
                3'd0:    ok = 1'b1;
                3'd1:    ok = ~lo[0];
                3'd2:    ok = (lo == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: ok = 1'b1;
                3'd1, 3'd5: ok = ~lo[0];
                3'd2:       ok = (lo == 2'b00);
                default:    ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Store byte enables and lane-replicated data, packed as {be, wdata}.
    function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] d);
        logic [3:0]  be;
        logic [31:0] wd;
        case (f3)
            3'd0: begin
                be = 4'b0001 << lo;
                wd = {4{d[7:0]}};
            end
            3'd1: begin
                be = lo[1] ? 4'b1100 : 4'b0011;
                wd = {2{d[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = d;
            end
        endcase
        return {be, wd};
    endfunction

    // Pick the addressed byte/halfword out of the read word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                 input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        case (lo)
            2'd0:    b = r[7:0];
            2'd1:    b = r[15:8];
            2'd2:    b = r[23:16];
            default: b = r[31:24];
        endcase
        h = lo[1] ? r[31:16] : r[15:0];
        case (f3)
            3'd0:    v = {{24{b[7]}}, b};
            3'd4:    v = {24'h000000, b};
            3'd1:    v = {{16{h[15]}}, h};
            3'd5:    v = {16'h0000, h};
            default: v = r;
        endcase
        return v;
    endfunction

    state_t      state_r, state_s;
    logic        req_r, req_s, we_r, we_s;
    logic [31:0] addr_r, addr_s, wdata_r, wdata_s;
    logic [3:0]  be_r, be_s;
    logic [2:0]  func3_r, func3_s;
    logic [1:0]  lo_r, lo_s;
    logic [4:0]  rd_r, rd_s;
    logic        rw_r, rw_s, load_r, load_s, m2r_r, m2r_s;
    logic [15:0] cnt_r, cnt_s;
    logic        wb_valid_r, wb_valid_s, wb_rw_r, wb_rw_s;
    logic [31:0] wb_data_r, wb_data_s;
    logic [4:0]  wb_reg_r, wb_reg_s;
    logic        pc_src_r, pc_src_s, fault_r, fault_s;
    logic [31:0] pc_target_r, pc_target_s;
    logic        stall_s;
    logic [35:0] lanes_s;

    // Next-state, handshake and write-back decisions.
    always_comb begin
        state_s     = state_r;
        req_s       = req_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        be_s        = be_r;
        func3_s     = func3_r;
        lo_s        = lo_r;
        rd_s        = rd_r;
        rw_s        = rw_r;
        load_s      = load_r;
        m2r_s       = m2r_r;
        cnt_s       = cnt_r;
        wb_valid_s  = 1'b0;
        wb_data_s   = wb_data_r;
        wb_reg_s    = wb_reg_r;
        wb_rw_s     = wb_rw_r;
        pc_src_s    = 1'b0;
        pc_target_s = pc_target_r;
        fault_s     = 1'b0;
        stall_s     = 1'b0;
        lanes_s     = store_lanes(i_func3, i_alu_out[1:0], i_store_data);
        case (state_r)
            IDLE: begin
                if (i_valid && !(i_mem_read || i_mem_write)) begin
                    wb_valid_s  = 1'b1;
                    wb_data_s   = i_alu_out;
                    wb_reg_s    = i_write_reg;
                    wb_rw_s     = i_reg_write;
                    pc_src_s    = i_branch;
                    pc_target_s = i_branch_target;
                end else if (i_valid && access_ok(i_mem_read, i_mem_write, i_func3, i_alu_out[1:0])) begin
                    stall_s = 1'b1;
                    state_s = REQ;
                    req_s   = 1'b1;
                    we_s    = i_mem_write;
                    addr_s  = {i_alu_out[31:2], 2'b00};
                    func3_s = i_func3;
                    lo_s    = i_alu_out[1:0];
                    rd_s    = i_write_reg;
                    rw_s    = i_reg_write;
                    load_s  = i_mem_read;
                    m2r_s   = i_mem_to_reg;
                    cnt_s   = 16'd0;
                    if (i_mem_write) begin
                        be_s    = lanes_s[35:32];
                        wdata_s = lanes_s[31:0];
                    end else begin
                        be_s    = 4'b1111;
                        wdata_s = 32'h0000_0000;
                    end
                end else if (i_valid) begin
                    // Illegal or misaligned: retire as a faulting no-write.
                    fault_s    = 1'b1;
                    wb_valid_s = 1'b1;
                    wb_reg_s   = i_write_reg;
                    wb_rw_s    = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (dmem.i_dmem_ack) begin
                    // Stall released in the ack cycle so upstream advances at this edge.
                    state_s    = IDLE;
                    req_s      = 1'b0;
                    wb_valid_s = 1'b1;
                    wb_reg_s   = rd_r;
                    if (load_r) begin
                        wb_data_s = m2r_r ? load_extract(func3_r, lo_r, dmem.i_dmem_rdata) : addr_r;
                        wb_rw_s   = rw_r;
                    end else begin
                        wb_rw_s   = 1'b0;
                    end
                end else if (cnt_r == TIMEOUT_LAST) begin
                    stall_s    = 1'b1;
                    state_s    = IDLE;
                    req_s      = 1'b0;
                    fault_s    = 1'b1;
                    wb_valid_s = 1'b1;
                    wb_reg_s   = rd_r;
                    wb_rw_s    = 1'b0;
                end else begin
                    stall_s = 1'b1;
                    cnt_s   = cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // Stage state and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= IDLE;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            be_r        <= 4'b0000;
            func3_r     <= 3'd0;
            lo_r        <= 2'd0;
            rd_r        <= 5'd0;
            rw_r        <= 1'b0;
            load_r      <= 1'b0;
            m2r_r       <= 1'b0;
            cnt_r       <= 16'd0;
            wb_valid_r  <= 1'b0;
            wb_data_r   <= 32'h0000_0000;
            wb_reg_r    <= 5'd0;
            wb_rw_r     <= 1'b0;
            pc_src_r    <= 1'b0;
            pc_target_r <= 32'h0000_0000;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            req_r       <= req_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            be_r        <= be_s;
            func3_r     <= func3_s;
            lo_r        <= lo_s;
            rd_r        <= rd_s;
            rw_r        <= rw_s;
            load_r      <= load_s;
            m2r_r       <= m2r_s;
            cnt_r       <= cnt_s;
            wb_valid_r  <= wb_valid_s;
            wb_data_r   <= wb_data_s;
            wb_reg_r    <= wb_reg_s;
            wb_rw_r     <= wb_rw_s;
            pc_src_r    <= pc_src_s;
            pc_target_r <= pc_target_s;
            fault_r     <= fault_s;
        end
    end

    // Stall is combinational; forced low while reset is asserted.
    assign o_stall           = stall_s & i_reset;
    assign dmem.o_dmem_req   = req_r;
    assign dmem.o_dmem_we    = we_r;
    assign dmem.o_dmem_addr  = addr_r;
    assign dmem.o_dmem_wdata = wdata_r;
    assign dmem.o_dmem_be    = be_r;
    assign o_wb_valid        = wb_valid_r;
    assign o_wb_data         = wb_data_r;
    assign o_wb_reg          = wb_reg_r;
    assign o_wb_reg_write    = wb_rw_r;
    assign o_pc_src          = pc_src_r;
    assign o_pc_target       = pc_target_r;
    assign o_mem_fault       = fault_r;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (ACK_TIMEOUT = 4).
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] alu_out = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [4:0]  write_reg = 5'd0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  func3 = 3'd0;
    logic        mem_to_reg = 1'b0, reg_write = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        stall, wb_valid, wb_reg_write, pc_src, mem_fault;
    logic [31:0] wb_data, pc_target;
    logic [4:0]  wb_reg;
    int          checks = 0;
    int          errors = 0;

    mem_stage_if dmem_bus ();

    mem_stage #(.ACK_TIMEOUT(4)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_alu_out(alu_out),
        .i_store_data(store_data), .i_write_reg(write_reg), .i_mem_read(mem_read),
        .i_mem_write(mem_write), .i_func3(func3), .i_mem_to_reg(mem_to_reg),
        .i_reg_write(reg_write), .i_branch(branch), .i_branch_target(branch_target),
        .dmem(dmem_bus.master), .o_stall(stall), .o_wb_valid(wb_valid),
        .o_wb_data(wb_data), .o_wb_reg(wb_reg), .o_wb_reg_write(wb_reg_write),
        .o_pc_src(pc_src), .o_pc_target(pc_target), .o_mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
        valid = v; mem_read = rd; mem_write = wr; func3 = f3;
        alu_out = a; store_data = sd; write_reg = r;
        mem_to_reg = rd; reg_write = ~wr;
    endtask

    initial begin
        dmem_bus.i_dmem_ack = 1'b0;
        dmem_bus.i_dmem_rdata = 32'h0;
        #1;
        chk("rst_req", {31'd0, dmem_bus.o_dmem_req}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_fault", {31'd0, mem_fault}, 32'd0);
        chk("rst_data", wb_data, 32'd0);
        step(); step();
        rst_n = 1'b1;

        // ADD, result 5 -> rd 3
        set_op(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0005, 32'h0, 5'd3);
        #1 chk("add_stall", {31'd0, stall}, 32'd0);
        step();
        chk("add_wbv", {31'd0, wb_valid}, 32'd1);
        chk("add_data", wb_data, 32'h0000_0005);
        chk("add_reg", {27'd0, wb_reg}, 32'd3);
        chk("add_rw", {31'd0, wb_reg_write}, 32'd1);
        chk("add_req", {31'd0, dmem_bus.o_dmem_req}, 32'd0);
        valid = 1'b0;
        step();
        chk("add_pulse", {31'd0, wb_valid}, 32'd0);

        // Taken branch redirect
        set_op(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0009, 32'h0, 5'd0);
        branch = 1'b1; branch_target = 32'h0000_0400;
        step();
        chk("br_src", {31'd0, pc_src}, 32'd1);
        chk("br_tgt", pc_target, 32'h0000_0400);
        valid = 1'b0; branch = 1'b0;
        step();
        chk("br_pulse", {31'd0, pc_src}, 32'd0);

        // LB 0x1003, ack on second request cycle
        set_op(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0, 5'd5);
        #1 chk("lb_stall0", {31'd0, stall}, 32'd1);
        step();
        chk("lb_req1", {31'd0, dmem_bus.o_dmem_req}, 32'd1);
        chk("lb_addr", dmem_bus.o_dmem_addr, 32'h0000_1000);
        chk("lb_we", {31'd0, dmem_bus.o_dmem_we}, 32'd0);
        chk("lb_be", {28'd0, dmem_bus.o_dmem_be}, 32'hF);
        chk("lb_stall1", {31'd0, stall}, 32'd1);
        step();
        chk("lb_req2", {31'd0, dmem_bus.o_dmem_req}, 32'd1);
        dmem_bus.i_dmem_ack = 1'b1; dmem_bus.i_dmem_rdata = 32'h80FF_1234; valid = 1'b0;
        #1 chk("lb_ackstall", {31'd0, stall}, 32'd0);
        step();
        dmem_bus.i_dmem_ack = 1'b0;
        chk("lb_reqdrop", {31'd0, dmem_bus.o_dmem_req}, 32'd0);
        chk("lb_wbv", {31'd0, wb_valid}, 32'd1);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_reg", {27'd0, wb_reg}, 32'd5);
        chk("lb_rw", {31'd0, wb_reg_write}, 32'd1);

        // LBU 0x1003, zero-wait ack
        set_op(1'b1, 1'b1, 1'b0, 3'd4, 32'h0000_1003, 32'h0, 5'd6);
        step();
        dmem_bus.i_dmem_ack = 1'b1; valid = 1'b0;
        step();
        dmem_bus.i_dmem_ack = 1'b0;
        chk("lbu_data", wb_data, 32'h0000_0080);

        // LH 0x1002 -> upper halfword sign-extended
        set_op(1'b1, 1'b1, 1'b0, 3'd1, 32'h0000_1002, 32'h0, 5'd8);
        step();
        dmem_bus.i_dmem_ack = 1'b1; valid = 1'b0;
        step();
        dmem_bus.i_dmem_ack = 1'b0;
        chk("lh_data", wb_data, 32'hFFFF_80FF);

        // SH 0x2002
        set_op(1'b1, 1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 5'd0);
        step();
        chk("sh_req", {31'd0, dmem_bus.o_dmem_req}, 32'd1);
        chk("sh_we", {31'd0, dmem_bus.o_dmem_we}, 32'd1);
        chk("sh_be", {28'd0, dmem_bus.o_dmem_be}, 32'hC);
        chk("sh_wdata", dmem_bus.o_dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", dmem_bus.o_dmem_addr, 32'h0000_2000);
        dmem_bus.i_dmem_ack = 1'b1; valid = 1'b0;
        step();
        dmem_bus.i_dmem_ack = 1'b0;
        chk("sh_wbv", {31'd0, wb_valid}, 32'd1);
        chk("sh_rw", {31'd0, wb_reg_write}, 32'd0);

        // SB 0x4001
        set_op(1'b1, 1'b0, 1'b1, 3'd0, 32'h0000_4001, 32'h1234_56A5, 5'd0);
        step();
        chk("sb_be", {28'd0, dmem_bus.o_dmem_be}, 32'h2);
        chk("sb_wdata", dmem_bus.o_dmem_wdata, 32'hA5A5_A5A5);
        dmem_bus.i_dmem_ack = 1'b1; valid = 1'b0;
        step();
        dmem_bus.i_dmem_ack = 1'b0;

        // LW misaligned 0x1001
        set_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_1001, 32'h0, 5'd9);
        #1 chk("lwm_stall", {31'd0, stall}, 32'd0);
        step();
        chk("lwm_req", {31'd0, dmem_bus.o_dmem_req}, 32'd0);
        chk("lwm_fault", {31'd0, mem_fault}, 32'd1);
        chk("lwm_wbv", {31'd0, wb_valid}, 32'd1);
        chk("lwm_rw", {31'd0, wb_reg_write}, 32'd0);
        valid = 1'b0;
        step();
        chk("lwm_pulse", {31'd0, mem_fault}, 32'd0);

        // Timeout: no ack, req high exactly 4 cycles
        set_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'h0, 5'd10);
        step();
        chk("to_req0", {31'd0, dmem_bus.o_dmem_req}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("to_reqn", {31'd0, dmem_bus.o_dmem_req}, 32'd1);
        end
        step();
        chk("to_drop", {31'd0, dmem_bus.o_dmem_req}, 32'd0);
        chk("to_fault", {31'd0, mem_fault}, 32'd1);
        chk("to_wbv", {31'd0, wb_valid}, 32'd1);
        chk("to_rw", {31'd0, wb_reg_write}, 32'd0);
        set_op(1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0011, 32'h0, 5'd7);
        step();
        chk("to_add_wbv", {31'd0, wb_valid}, 32'd1);
        chk("to_add_data", wb_data, 32'h0000_0011);
        chk("to_add_fault", {31'd0, mem_fault}, 32'd0);
        valid = 1'b0;
        step();

        // Async reset during an outstanding access
        set_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_5000, 32'h0, 5'd11);
        step();
        chk("rr_req", {31'd0, dmem_bus.o_dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_reqdrop", {31'd0, dmem_bus.o_dmem_req}, 32'd0);
        chk("rr_stall", {31'd0, stall}, 32'd0);
        chk("rr_wbv", {31'd0, wb_valid}, 32'd0);
        valid = 1'b0;
        #1 rst_n = 1'b1;
        dmem_bus.i_dmem_ack = 1'b1; dmem_bus.i_dmem_rdata = 32'hDEAD_BEEF;
        step();
        chk("rr_lateack", {31'd0, wb_valid}, 32'd0);
        chk("rr_req2", {31'd0, dmem_bus.o_dmem_req}, 32'd0);
        dmem_bus.i_dmem_ack = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the RV32 core: consumes the EX→MEM pipeline register produced by the execute-stage ALU and turns it into MEM→WB results. It issues loads and stores to the data memory over a req/ack handshake, performs byte-lane steering and load sign/zero extension, and stalls the upstream pipeline while an access is outstanding. It also registers the branch decision and target to the fetch stage, and guards against hung accesses with a timeout.

## Interface
- ACK_TIMEOUT, 255: maximum cycles `o_dmem_req` may stay high without `i_dmem_ack`; must be 1..65535.
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  EX→MEM register holds a valid instruction.
- i_alu_out  in  32  ALUOutput: effective address for loads/stores, otherwise the result.
- i_store_data  in  32  rd2: store source register.
- i_write_reg  in  5  destination register index.
- i_mem_read / i_mem_write  in  1 each  load / store; both high is illegal.
- i_func3  in  3  access size: 0 B, 1 H, 2 W, 4 BU, 5 HU (loads); 0/1/2 (stores).
- i_mem_to_reg, i_reg_write  in  1 each  write-back controls.
- i_branch  in  1  branch taken; i_branch_target  in  32  AddSum.
- o_stall  out  1  freeze the IF/ID/EX registers this cycle.
- o_dmem_req  out  1  access request; o_dmem_we  out  1  write enable.
- o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- o_dmem_wdata  out  32  lane-replicated store data; o_dmem_be  out  4  byte enables.
- i_dmem_ack  in  1  access done; i_dmem_rdata  in  32  read word, valid with ack.
- o_wb_valid  out  1; o_wb_data  out  32; o_wb_reg  out  5; o_wb_reg_write  out  1  MEM→WB register.
- o_pc_src  out  1; o_pc_target  out  32  registered redirect to fetch.
- o_mem_fault  out  1  one-cycle pulse: misaligned, illegal func3, or timeout.

## Operation
- The FSM has two states, IDLE and REQ. Reset drives IDLE, and every output is 0.
- **IDLE, non-memory op** (i_valid, no read/write): at the edge, o_wb_valid=1, o_wb_data=i_alu_out, o_wb_reg=i_write_reg, o_wb_reg_write=i_reg_write. o_pc_src=i_branch and o_pc_target=i_branch_target are registered the same way. No stall.
- **IDLE, legal memory op:** o_stall=1 combinationally. At the edge:
  - the address, be, wdata, func3 and rd are latched;
  - o_dmem_req=1 and o_dmem_we=i_mem_write;
  - the FSM goes to REQ and the timeout counter clears.
- **Alignment rules:** H/HU/SH need addr[0]=0. W/SW need addr[1:0]=0. Store func3 must be 0..2 and load func3 must be in {0,1,2,4,5}.
- **Faults:** an illegal or misaligned op issues no request. The next edge gives o_mem_fault=1, o_wb_valid=1, o_wb_reg_write=0, and no stall.
- **Store lanes:**
  - SB: be=0001<<addr[1:0], wdata={4{rd2[7:0]}}.
  - SH: be=0011 or 1100 by addr[1], wdata={2{rd2[15:0]}}.
  - SW: be=1111, wdata=rd2.
  - For loads, o_dmem_be=1111 and o_dmem_we=0.
- **Load extract:** select the byte or halfword at addr[1:0] from i_dmem_rdata. Sign-extend for B/H and zero-extend for BU/HU.
- **REQ:** all o_dmem_* outputs are held stable and o_stall=1.
  - **Ack:** at the edge where i_dmem_ack=1, o_dmem_req drops and the FSM returns to IDLE. o_wb_valid=1; for a load, o_wb_data is the extracted load value; for a store, o_wb_reg_write=0. o_stall is 0 in the ack cycle (combinational on ack), so the next instruction is accepted at that edge.
  - **Timeout:** if the counter reaches ACK_TIMEOUT without ack, the FSM aborts to IDLE. o_mem_fault=1, o_wb_valid=1, o_wb_reg_write=0, req drops.
- i_dmem_ack while in IDLE is ignored.

## Timing
- A non-memory op produces its WB result 1 cycle after acceptance.
- A memory op has latency 1 + N cycles, where N is the number of cycles with req high before ack, N≥1. A zero-wait memory gives a 2-cycle total.
- o_wb_valid, o_mem_fault and o_pc_src are single-cycle pulses per instruction.
- Asynchronous reset mid-access forces IDLE immediately. o_dmem_req, o_stall and all WB outputs go to 0 without waiting for the clock, and a late ack after reset is ignored.
- i_* inputs are sampled only in IDLE. Upstream holds them stable while o_stall=1.

## Test plan
- ADD result 0x0000_0005, rd=3, no mem → next cycle o_wb_valid=1, data=5, reg=3, reg_write=1, no req.
- LB addr 0x1003, rdata 0x80FF_1234, ack after 2 cycles → req high 2 cycles, addr 0x1000, wb data 0xFFFF_FF80; LBU of the same gives 0x0000_0080.
- SH addr 0x2002, rd2 0x0000_BEEF → req, we=1, be=1100, wdata 0xBEEF_BEEF, wb reg_write=0.
- LW addr 0x1001 → no req, o_mem_fault pulse, reg_write=0, o_stall never high.
- ACK_TIMEOUT=4, no ack → req high exactly 4 cycles, then fault pulse and return to IDLE; the next ADD completes normally.
- Reset low during REQ → req and stall drop immediately. An ack after reset release gives no wb_valid.
